// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: state encoding and default sizing.
package mult_pkg;

    localparam int N_DEF     = 4;
    localparam int CNT_W_DEF = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        LOAD  = S_LOAD,
        ADD   = S_ADD,
        SHIFT = S_SHIFT,
        DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/mult_bit_counter.sv
// Iteration counter for the multiplier sequencer; flags the final iteration.
module mult_bit_counter #(
    parameter int N     = mult_pkg::N_DEF,
    parameter int CNT_W = mult_pkg::CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] K,
    output logic             Last
);

    always_ff @(posedge Clk) begin
        if (!Rst_n || clr)
            K <= '0;
        else if (inc)
            K <= K + 1'b1;
    end

    assign Last = (K == CNT_W'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Shift-add multiplier sequencer: load, N x (conditional add, shift), then done.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             St,
    input  logic             M,
    output logic             Load,
    output logic             Sh,
    output logic             Ad,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] K
);

    state_t state, state_nxt;
    logic   clr, inc, last;

    always_ff @(posedge Clk) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (St) state_nxt = LOAD;
            LOAD:    state_nxt = ADD;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = last ? DONE : ADD;
            DONE:    if (!St) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // K holds N-1 through DONE; it only clears on a fresh load or on leaving DONE
    assign clr = (state == LOAD) || ((state == DONE) && !St);
    assign inc = (state == SHIFT) && !last;

    mult_bit_counter #(.N(N), .CNT_W(CNT_W)) u_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clr   (clr),
        .inc   (inc),
        .K     (K),
        .Last  (last)
    );

    always_comb begin
        Load = (state == LOAD);
        Sh   = (state == SHIFT);
        Ad   = (state == ADD) && M;
        Busy = (state == LOAD) || (state == ADD) || (state == SHIFT);
        Done = (state == DONE);
    end

endmodule
